clock_tick_sched: RTL and testbench
===================================

CLOCK_TICK_SCHED -- requirements
Module: clock_tick_sched

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, display-scan tick rate; reset divisor = CLK_HZ/SCAN_HZ.
REQ-003 Parameter DEB_HZ, default 100, debounce tick rate; reset divisor = CLK_HZ/DEB_HZ.
REQ-004 Parameter SEC_HZ, default 1, game-clock tick rate; reset divisor = CLK_HZ/SEC_HZ.
REQ-005 CLK_50MHZ  in  1  sole clock; all logic on rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 START / STOP / PAUSE  in  1 each  game-clock control, level-sampled each cycle.
REQ-008 LOAD_REQ  in  1  divisor-load request, held high until LOAD_ACK.
REQ-009 LOAD_CH  in  2  channel: 0 scan, 1 debounce, 2 second, 3 invalid.
REQ-010 LOAD_VAL  in  26  new divisor.
REQ-011 LOAD_ACK  out  1  one-cycle load acknowledge.
REQ-012 LOAD_ERR  out  1  valid only with LOAD_ACK; 1 = load rejected.
REQ-013 TICK_SCAN / TICK_DEB / TICK_SEC  out  1 each  one-cycle enable pulses.
REQ-014 STATE  out  2  00 STOPPED, 01 RUN, 10 PAUSED.
REQ-015 SEC_CNT  out  16  count of TICK_SEC pulses since last STOPPED.

Function
REQ-016 Each channel: 26-bit counter; on an edge with counter == div-1, counter <= 0 and TICK <= 1; otherwise counter increments and TICK <= 0; period exactly div cycles.
REQ-017 Scan and debounce channels free-run from reset release regardless of STATE.
REQ-018 Second channel counts only in RUN; in PAUSED it holds its counter value; entering STOPPED clears it.
REQ-019 FSM: STOPPED -START-> RUN; RUN -PAUSE-> PAUSED; PAUSED -START-> RUN; RUN/PAUSED -STOP-> STOPPED.
REQ-020 Priority when simultaneous: STOP > PAUSE > START.
REQ-021 SEC_CNT increments on the same edge TICK_SEC is asserted and wraps 65535 -> 0; it clears on entry to STOPPED.
REQ-022 Load: LOAD_REQ rising level is sampled; LOAD_ACK is high exactly one cycle, one cycle after the sample.
REQ-023 A new load is accepted only after LOAD_REQ has been observed low; REQ held high after ACK yields no second ACK.
REQ-024 LOAD_CH == 3 or LOAD_VAL < 2 -> LOAD_ERR = 1, no state change.
REQ-025 Valid load: divisor updated and that channel's counter cleared on the ACK edge; no tick emitted on that edge.
REQ-026 Load coinciding with a channel wrap: load wins, tick suppressed.

Reset
REQ-027 RST_N low: all counters 0, divisors = parameter values, STATE = STOPPED, SEC_CNT = 0, all ticks / LOAD_ACK / LOAD_ERR = 0, load edge detector armed.
REQ-028 Reset mid-load drops the pending request; no ACK is issued for it.

Configuration
REQ-029 Macro CLOCK_TICK_LOAD_EN defined: REQ-022..REQ-026 active.
REQ-030 Macro CLOCK_TICK_LOAD_EN undefined: load ports remain; LOAD_ACK and LOAD_ERR are tied 0; divisors are fixed at parameter values.

Structure
REQ-031 Package clock_tick_pkg holds: DIV_W = 26, SEC_W = 16, STATE encodings, channel indices CH_SCAN / CH_DEB / CH_SEC.
REQ-032 Sub-module tick_div (counter, enable, clear, load, tick) is instantiated three times; FSM, load handshake and SEC_CNT live in clock_tick_sched.

Verification (CLK_HZ=1000, SCAN_HZ=100, DEB_HZ=50, SEC_HZ=10 -> divisors 10/20/100)
REQ-033 Release reset, run 200 cycles -> 20 TICK_SCAN, 10 TICK_DEB, 0 TICK_SEC pulses; STATE = 00.
REQ-034 START 1 cycle, run 250 cycles; PAUSE, 50 cycles; START, run 50 cycles -> SEC_CNT = 2 after first run, held at 2 while PAUSED, 3 after resume.
REQ-035 START, PAUSE and STOP together in RUN -> STATE = 00 next cycle; SEC_CNT = 0.
REQ-036 Load CH 0, VAL 4 -> ACK one cycle later, ERR = 0; TICK_SCAN period becomes 4; REQ held 5 more cycles -> no further ACK.
REQ-037 Load CH 3 -> ACK with ERR = 1; load CH 1, VAL 1 -> ACK with ERR = 1; debounce period remains 20.
REQ-038 Assert RST_N low during RUN with LOAD_REQ high -> all outputs 0, STATE = 00, no ACK; after release, divisors are 10/20/100.

Source files
------------

// File: rtl/clock_tick_pkg.sv
// Shared widths, FSM encoding and channel indices for the tick scheduler.
// Also holds the load-validity rule used by the divisor-load handshake.
package clock_tick_pkg;

  localparam int unsigned DIV_W = 26;
  localparam int unsigned SEC_W = 16;

  typedef enum logic [1:0] {
    StStopped = 2'b00,
    StRun     = 2'b01,
    StPaused  = 2'b10
  } state_e;

  localparam logic [1:0] CH_SCAN    = 2'd0;
  localparam logic [1:0] CH_DEB     = 2'd1;
  localparam logic [1:0] CH_SEC     = 2'd2;
  localparam logic [1:0] CH_INVALID = 2'd3;

  // Smallest divisor that still yields a pulse with a low phase.
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  function automatic logic load_bad(input logic [1:0] ch, input logic [DIV_W-1:0] val);
    return (ch == CH_INVALID) || (val < MIN_DIV);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Programmable tick divider: one-cycle tick every div_q enabled cycles.
// A load replaces the divisor and restarts the count; a clear only restarts it.
module tick_div
  import clock_tick_pkg::*;
#(
  parameter logic [DIV_W-1:0] DivRst = DIV_W'(10)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tick_o,
  output logic             tick_next_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    // Load beats a coincident wrap, so the tick on that edge is dropped.
    if (load_i) begin
      div_d = load_val_i;
      cnt_d = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      div_q  <= DivRst;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o      = tick_q;
  assign tick_next_o = tick_d;

endmodule

// File: rtl/clock_tick_sched.sv
// Scan/debounce/second tick scheduler with a STOPPED/RUN/PAUSED game clock.
// Runtime divisor loading is built only when CLOCK_TICK_LOAD_EN is defined.
module clock_tick_sched
  import clock_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned DEB_HZ  = 100,
  parameter int unsigned SEC_HZ  = 1
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             LOAD_REQ,
  input  logic [1:0]       LOAD_CH,
  input  logic [DIV_W-1:0] LOAD_VAL,
  output logic             LOAD_ACK,
  output logic             LOAD_ERR,
  output logic             TICK_SCAN,
  output logic             TICK_DEB,
  output logic             TICK_SEC,
  output logic [1:0]       STATE,
  output logic [SEC_W-1:0] SEC_CNT
);

  localparam logic [DIV_W-1:0] ScanDiv = DIV_W'(CLK_HZ / SCAN_HZ);
  localparam logic [DIV_W-1:0] DebDiv  = DIV_W'(CLK_HZ / DEB_HZ);
  localparam logic [DIV_W-1:0] SecDiv  = DIV_W'(CLK_HZ / SEC_HZ);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             enter_stop;
  logic             sec_en;
  logic             sec_tick_next;
  logic             scan_tick_next;
  logic             deb_tick_next;
  logic             load_scan, load_deb, load_sec;
  logic [DIV_W-1:0] load_val;

  // Game-clock FSM; STOP outranks PAUSE, which outranks START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStopped: if (!STOP && !PAUSE && START) state_d = StRun;
      StRun: begin
        if (STOP)       state_d = StStopped;
        else if (PAUSE) state_d = StPaused;
      end
      StPaused: begin
        if (STOP)                 state_d = StStopped;
        else if (!PAUSE && START) state_d = StRun;
      end
      default: state_d = StStopped;
    endcase
  end

  assign enter_stop = (state_q != StStopped) && (state_d == StStopped);
  assign sec_en     = (state_q == StRun);

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (enter_stop) begin
      sec_cnt_d = '0;
    end else if (sec_tick_next) begin
      sec_cnt_d = sec_cnt_q + SEC_W'(1);
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StStopped;
      sec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

`ifdef CLOCK_TICK_LOAD_EN
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [1:0]       ch_q, ch_d;
  logic [DIV_W-1:0] val_q, val_d;
  logic             load_ok;

  // A request is captured once per high phase; ACK and the load follow one edge later.
  always_comb begin
    armed_d = armed_q;
    pend_d  = 1'b0;
    ch_d    = ch_q;
    val_d   = val_q;
    ack_d   = pend_q;
    err_d   = pend_q && load_bad(ch_q, val_q);
    if (!LOAD_REQ) begin
      armed_d = 1'b1;
    end else if (armed_q) begin
      armed_d = 1'b0;
      pend_d  = 1'b1;
      ch_d    = LOAD_CH;
      val_d   = LOAD_VAL;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      armed_q <= 1'b1;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ch_q    <= CH_SCAN;
      val_q   <= '0;
    end else begin
      armed_q <= armed_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      val_q   <= val_d;
    end
  end

  assign load_ok   = pend_q && !load_bad(ch_q, val_q);
  assign load_scan = load_ok && (ch_q == CH_SCAN);
  assign load_deb  = load_ok && (ch_q == CH_DEB);
  assign load_sec  = load_ok && (ch_q == CH_SEC);
  assign load_val  = val_q;
  assign LOAD_ACK  = ack_q;
  assign LOAD_ERR  = err_q;
`else
  logic unused_load;

  assign unused_load = ^{LOAD_REQ, LOAD_CH, LOAD_VAL};
  assign load_scan   = 1'b0;
  assign load_deb    = 1'b0;
  assign load_sec    = 1'b0;
  assign load_val    = '0;
  assign LOAD_ACK    = 1'b0;
  assign LOAD_ERR    = 1'b0;
`endif

  tick_div #(
    .DivRst(ScanDiv)
  ) u_div_scan (
    .clk_i      (CLK_50MHZ),
    .rst_ni     (RST_N),
    .en_i       (1'b1),
    .clr_i      (1'b0),
    .load_i     (load_scan),
    .load_val_i (load_val),
    .tick_o     (TICK_SCAN),
    .tick_next_o(scan_tick_next)
  );

  tick_div #(
    .DivRst(DebDiv)
  ) u_div_deb (
    .clk_i      (CLK_50MHZ),
    .rst_ni     (RST_N),
    .en_i       (1'b1),
    .clr_i      (1'b0),
    .load_i     (load_deb),
    .load_val_i (load_val),
    .tick_o     (TICK_DEB),
    .tick_next_o(deb_tick_next)
  );

  tick_div #(
    .DivRst(SecDiv)
  ) u_div_sec (
    .clk_i      (CLK_50MHZ),
    .rst_ni     (RST_N),
    .en_i       (sec_en),
    .clr_i      (enter_stop),
    .load_i     (load_sec),
    .load_val_i (load_val),
    .tick_o     (TICK_SEC),
    .tick_next_o(sec_tick_next)
  );

  logic unused_tick_next;
  assign unused_tick_next = scan_tick_next ^ deb_tick_next;

  assign STATE   = state_q;
  assign SEC_CNT = sec_cnt_q;

endmodule

// File: tb/tb_clock_tick_sched.sv
// Bench for clock_tick_sched: directed scenarios plus random control/load traffic,
// checked every cycle against an event-scheduling reference model.
module tb_clock_tick_sched;

`ifdef CLOCK_TICK_LOAD_EN
  localparam bit LoadEn = 1'b1;
`else
  localparam bit LoadEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        load_req = 1'b0;
  logic [1:0]  load_ch = 2'd0;
  logic [25:0] load_val = 26'd0;
  logic        load_ack, load_err, tick_scan, tick_deb, tick_sec;
  logic [1:0]  state;
  logic [15:0] sec_cnt;

  clock_tick_sched #(
    .CLK_HZ (1000),
    .SCAN_HZ(100),
    .DEB_HZ (50),
    .SEC_HZ (10)
  ) dut (
    .CLK_50MHZ(clk),
    .RST_N    (rst_n),
    .START    (start),
    .STOP     (stop),
    .PAUSE    (pause),
    .LOAD_REQ (load_req),
    .LOAD_CH  (load_ch),
    .LOAD_VAL (load_val),
    .LOAD_ACK (load_ack),
    .LOAD_ERR (load_err),
    .TICK_SCAN(tick_scan),
    .TICK_DEB (tick_deb),
    .TICK_SEC (tick_sec),
    .STATE    (state),
    .SEC_CNT  (sec_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_scan, n_deb, n_sec, n_ack;

  // Reference model: ticks are scheduled as absolute edge numbers (free channels)
  // or as counts of RUN edges (second channel).
  int unsigned m_div[3];
  longint      m_next[3];
  longint      m_n, m_run;
  bit          m_tick[3];
  int          m_state, m_sec;
  bit          m_ack, m_err, m_armed, m_pend;
  int          m_pch, m_pval;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div[0] = 10; m_div[1] = 20; m_div[2] = 100;
    m_n = 0; m_run = 0;
    for (int i = 0; i < 3; i++) begin
      m_next[i] = m_div[i];
      m_tick[i] = 1'b0;
    end
    m_state = 0; m_sec = 0;
    m_ack = 0; m_err = 0; m_armed = 1; m_pend = 0; m_pch = 0; m_pval = 0;
  endtask

  task automatic model_step();
    int lch = -1;
    int lval = 0;
    int nstate;
    bit enter_stop, en;
    m_n++;
    m_ack = 0;
    m_err = 0;
    if (LoadEn && m_pend) begin
      m_ack = 1;
      if (m_pch == 3 || m_pval < 2) m_err = 1;
      else begin
        lch  = m_pch;
        lval = m_pval;
      end
    end
    m_pend = 0;
    if (LoadEn) begin
      if (!load_req) m_armed = 1;
      else if (m_armed) begin
        m_armed = 0; m_pend = 1; m_pch = int'(load_ch); m_pval = int'(load_val);
      end
    end
    nstate = m_state;
    if (stop) nstate = 0;
    else if (pause) begin
      if (m_state == 1) nstate = 2;
    end else if (start) nstate = 1;
    enter_stop = (m_state != 0) && (nstate == 0);
    en = (m_state == 1);
    for (int i = 0; i < 2; i++) begin
      if (lch == i) begin
        m_div[i]  = lval;
        m_next[i] = m_n + lval;
        m_tick[i] = 0;
      end else begin
        m_tick[i] = (m_n == m_next[i]);
        if (m_tick[i]) m_next[i] += m_div[i];
      end
    end
    if (lch == 2) m_div[2] = lval;
    if (enter_stop || lch == 2) begin
      m_run = 0; m_next[2] = m_div[2]; m_tick[2] = 0;
    end else if (en) begin
      m_run++;
      m_tick[2] = (m_run == m_next[2]);
      if (m_tick[2]) m_next[2] += m_div[2];
    end else m_tick[2] = 0;
    if (enter_stop) m_sec = 0;
    else if (m_tick[2]) m_sec = (m_sec + 1) % 65536;
    m_state = nstate;
  endtask

  task automatic check_outputs();
    check("tick_scan", tick_scan, m_tick[0]);
    check("tick_deb", tick_deb, m_tick[1]);
    check("tick_sec", tick_sec, m_tick[2]);
    check("state", state, m_state);
    check("sec_cnt", sec_cnt, m_sec);
    check("load_ack", load_ack, m_ack);
    check("load_err", load_err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_outputs();
    n_scan += int'(tick_scan);
    n_deb  += int'(tick_deb);
    n_sec  += int'(tick_sec);
    n_ack  += int'(load_ack);
  endtask

  task automatic clear_counts();
    n_scan = 0; n_deb = 0; n_sec = 0; n_ack = 0;
  endtask

  // Period between two consecutive ticks of a channel, or -1 if not seen in budget.
  task automatic measure(input int ch, output int p);
    int t0 = -1;
    bit t;
    p = -1;
    for (int i = 0; i < 400 && p < 0; i++) begin
      step();
      t = (ch == 0) ? tick_scan : (ch == 1) ? tick_deb : tick_sec;
      if (t) begin
        if (t0 < 0) t0 = i;
        else p = i - t0;
      end
    end
  endtask

  initial begin
    int p;
    int hold = 0;
    int gap = 0;
    model_reset();
    clear_counts();
    repeat (3) step();
    rst_n = 1'b1;

    // Free-running channels from reset release; game clock idle.
    clear_counts();
    repeat (200) step();
    check("scan_pulses_200", n_scan, 20);
    check("deb_pulses_200", n_deb, 10);
    check("sec_pulses_200", n_sec, 0);
    check("state_idle", state, 0);

    // Run, pause, resume.
    start = 1'b1; step(); start = 1'b0;
    repeat (250) step();
    check("sec_cnt_run", sec_cnt, 2);
    pause = 1'b1; step(); pause = 1'b0;
    repeat (50) step();
    check("sec_cnt_paused", sec_cnt, 2);
    check("state_paused", state, 2);
    start = 1'b1; step(); start = 1'b0;
    repeat (50) step();
    check("sec_cnt_resumed", sec_cnt, 3);
    check("state_resumed", state, 1);

    // All three controls together: STOP wins.
    start = 1'b1; pause = 1'b1; stop = 1'b1; step();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    check("state_all_ctl", state, 0);
    check("sec_cnt_all_ctl", sec_cnt, 0);

    // Divisor loads.
    load_req = 1'b1; load_ch = 2'd0; load_val = 26'd4;
    step();
    check("ack_not_early", load_ack, 0);
    step();
    check("ack_scan", load_ack, LoadEn);
    check("err_scan", load_err, 0);
    clear_counts();
    repeat (5) step();
    check("no_second_ack", n_ack, 0);
    load_req = 1'b0; step();
    measure(0, p);
    check("scan_period", p, LoadEn ? 4 : 10);

    load_req = 1'b1; load_ch = 2'd3; load_val = 26'd50;
    step(); step();
    check("ack_ch3", load_ack, LoadEn);
    check("err_ch3", load_err, LoadEn);
    load_req = 1'b0; step();
    load_req = 1'b1; load_ch = 2'd1; load_val = 26'd1;
    step(); step();
    check("ack_val1", load_ack, LoadEn);
    check("err_val1", load_err, LoadEn);
    load_req = 1'b0; step();
    measure(1, p);
    check("deb_period", p, 20);

    // Random control and load traffic.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      pause = ($urandom_range(0, 39) == 0);
      if (!load_req && gap == 0 && $urandom_range(0, 39) == 0) begin
        load_req = 1'b1;
        load_ch  = 2'($urandom_range(0, 3));
        load_val = (load_ch == 2'd2) ? 26'($urandom_range(0, 150)) : 26'($urandom_range(0, 30));
        hold     = int'($urandom_range(2, 6));
      end
      step();
      if (load_req) begin
        hold--;
        if (hold == 0) begin
          load_req = 1'b0;
          gap = 2;
        end
      end else if (gap > 0) gap--;
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; load_req = 1'b0;
    repeat (3) step();

    // Reset in RUN with a load pending.
    start = 1'b1; step(); start = 1'b0;
    load_req = 1'b1; load_ch = 2'd0; load_val = 26'd7;
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_state", state, 0);
    check("rst_ack", load_ack, 0);
    load_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    clear_counts();
    repeat (200) step();
    check("post_rst_ack", n_ack, 0);
    check("post_rst_scan", n_scan, 20);
    check("post_rst_deb", n_deb, 10);
    check("post_rst_sec", n_sec, 0);
    start = 1'b1; step(); start = 1'b0;
    measure(2, p);
    check("post_rst_sec_period", p, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
